oam_dma: RTL and testbench
==========================

# oam_dma

Sprite DMA engine for the 2A03 top level, sitting directly between `cpu_2a03`'s bus outputs and the system memory bus. In idle it passes CPU address, data and R/W through unchanged. A CPU write to `$4014` triggers it: it freezes the CPU through a clock enable and copies 256 bytes from page `$XX00–$XXFF` to the PPU OAM data port `$2004` with 2A03-accurate read/write alignment.

## Interface
Parameters:
- `DMA_REG_ADDR`, default `16'h4014`: trigger register address.
- `OAM_DATA_ADDR`, default `16'h2004`: destination address for every DMA write.

Ports:
- `clock  in  1`: system clock (CPU rate).
- `nreset  in  1`: synchronous, active-high reset; `nreset=1` resets the block.
- `cpu_addr  in  16`: CPU address output.
- `cpu_data_out  in  8`: CPU write data.
- `cpu_rw  in  1`: CPU R/W (0=write, 1=read).
- `cpu_clock_enable  out  1`: gates the CPU's register updates; 0 freezes the CPU.
- `bus_addr  out  16`: system address bus.
- `bus_data_out  out  8`: system write data.
- `bus_rw  out  1`: system R/W.
- `bus_data_in  in  8`: system read data. It is also routed combinationally to the CPU's `data_in`.
- `dma_active  out  1`: 1 in any state other than IDLE.

## Operation
- **States:** IDLE, HALT, ALIGN, READ, WRITE.
- **Registers:**
  - `page[7:0]`: source page.
  - `idx[7:0]`: byte index.
  - `latch[7:0]`: byte read in READ.
  - `parity`: toggles every clock. Reset value 0.
- **IDLE:** `bus_addr=cpu_addr`, `bus_data_out=cpu_data_out`, `bus_rw=cpu_rw`, `cpu_clock_enable=1`.
- **Trigger:** in IDLE with `cpu_clock_enable=1`, `cpu_rw=0` and `cpu_addr=DMA_REG_ADDR`:
  - the write still passes through to the bus;
  - `page<=cpu_data_out`, `idx<=0`;
  - next state is HALT.
- **HALT:** `cpu_clock_enable=0`, `bus_rw=1`, `bus_addr=cpu_addr`. Next state is READ if the next cycle's parity is 0, otherwise ALIGN.
- **ALIGN:** same outputs as HALT. Next state is READ.
- **READ:**
  - `bus_addr={page,idx}`, `bus_rw=1`;
  - `latch<=bus_data_in`;
  - next state is WRITE.
- **WRITE:**
  - `bus_addr=OAM_DATA_ADDR`, `bus_rw=0`, `bus_data_out=latch`;
  - `idx<=idx+1` (8-bit, wraps);
  - if `idx==8'hFF`, next state is IDLE; else READ.
- **CPU bus is ignored while active:** CPU outputs are frozen during DMA, so no trigger is recognised while `dma_active=1`.
- **Reads are never mixed across pages:** `page` is fixed for the whole transfer. `idx` wrap to 0 coincides with the return to IDLE.
- **Outside a WRITE:** `bus_data_out=cpu_data_out`.

## Timing
- Reset (`nreset=1` at a clock edge) takes effect on that edge, in any state including mid-transfer:
  - state=IDLE, `idx=0`, `page=0`, `latch=0`, `parity=0`;
  - outputs immediately follow IDLE passthrough, with `cpu_clock_enable=1` and `dma_active=0`.
- All outputs are combinational from state plus the CPU inputs. No output registers.
- **Cycle counts.** Let the trigger-write cycle be T, with parity p.
  - T+1 is HALT.
  - If p=0: READ at T+2. Stall is 513 cycles (1 + 256×2).
  - If p=1: ALIGN at T+2, READ at T+3. Stall is 514 cycles.
- READ always occurs on parity-0 cycles; WRITE always on parity-1 cycles.
- `cpu_clock_enable` is low from T+1 through the final WRITE inclusive. It returns to 1 in the cycle after the last WRITE, when the CPU resumes its next bus cycle.
- **Back-to-back:** a new `$4014` write is accepted on the first IDLE cycle after a transfer.
- `cpu_data_in` (=`bus_data_in`) toggles during DMA. The CPU does not latch it while its clock enable is 0.

## Test plan
- **Passthrough:** `cpu_addr=16'h1234`, `cpu_rw=1`, no DMA → `bus_addr=16'h1234`, `bus_rw=1`, `cpu_clock_enable=1`, `dma_active=0` every cycle.
- **Even-aligned transfer:**
  - Stimulus: memory `$0200+i = i^8'h5A`; write `8'h02` to `$4014` on a parity-0 cycle.
  - Required: exactly 513 stalled cycles; 256 writes to `$2004` carrying `i^8'h5A` in order `i=0..255`; each read address is `$0200+i` on the cycle preceding its write.
- **Odd-aligned transfer:** the same write issued on a parity-1 cycle → 514 stalled cycles with one ALIGN cycle (`bus_rw=1`) before the first read of `$0200`.
- **Reset mid-transfer:** assert `nreset=1` for 1 cycle after write #100 → next cycle is IDLE with `cpu_clock_enable=1`; no further `$2004` writes.
- **Non-trigger writes:** a write to `$4015`, and a read of `$4014` → no DMA, `dma_active` stays 0.
- **Back-to-back:** write `8'h07` to `$4014`, then `8'h03` immediately after resume → two full transfers; the second sources `$0300–$03FF`.

Source files
------------

// File: rtl/oam_dma.sv
// oam_dma: sprite DMA engine between the 2A03 CPU core and the system bus.
// Passes CPU cycles through in idle; a write to DMA_REG_ADDR copies one page to OAM_DATA_ADDR.
`default_nettype none

module oam_dma #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        clock,
  input  logic        nreset,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_data_out,
  input  logic        cpu_rw,
  output logic        cpu_clock_enable,
  output logic [15:0] bus_addr,
  output logic [7:0]  bus_data_out,
  output logic        bus_rw,
  input  logic [7:0]  bus_data_in,
  output logic        dma_active
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } state_t;

  state_t      state;
  logic [7:0]  page;
  logic [7:0]  idx;
  logic [7:0]  latch;
  logic        parity;
  logic        trigger;

  assign trigger = (state == IDLE) && cpu_clock_enable && !cpu_rw &&
                   (cpu_addr == DMA_REG_ADDR);

  always_ff @(posedge clock) begin
    if (nreset) begin
      state  <= IDLE;
      page   <= 8'h00;
      idx    <= 8'h00;
      latch  <= 8'h00;
      parity <= 1'b0;
    end else begin
      parity <= ~parity;
      case (state)
        IDLE: begin
          if (trigger) begin
            page  <= cpu_data_out;
            idx   <= 8'h00;
            state <= HALT;
          end
        end
        // Reads must land on parity-0 cycles: the cycle after HALT has parity ~parity.
        HALT:  state <= parity ? READ : ALIGN;
        ALIGN: state <= READ;
        READ: begin
          latch <= bus_data_in;
          state <= WRITE;
        end
        WRITE: begin
          idx   <= idx + 8'd1;
          state <= (idx == 8'hFF) ? IDLE : READ;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    cpu_clock_enable = 1'b1;
    bus_addr         = cpu_addr;
    bus_data_out     = cpu_data_out;
    bus_rw           = cpu_rw;
    dma_active       = 1'b0;
    case (state)
      HALT, ALIGN: begin
        cpu_clock_enable = 1'b0;
        bus_rw           = 1'b1;
        dma_active       = 1'b1;
      end
      READ: begin
        cpu_clock_enable = 1'b0;
        bus_addr         = {page, idx};
        bus_rw           = 1'b1;
        dma_active       = 1'b1;
      end
      WRITE: begin
        cpu_clock_enable = 1'b0;
        bus_addr         = OAM_DATA_ADDR;
        bus_data_out     = latch;
        bus_rw           = 1'b0;
        dma_active       = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_oam_dma.sv
// tb_oam_dma: directed self-checking bench for oam_dma with a combinational memory model.
`default_nettype none

module tb_oam_dma;

  logic        clock = 1'b0;
  logic        nreset = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_data_out = 8'h00;
  logic        cpu_rw = 1'b1;
  logic        cpu_clock_enable;
  logic [15:0] bus_addr;
  logic [7:0]  bus_data_out;
  logic        bus_rw;
  logic [7:0]  bus_data_in;
  logic        dma_active;

  logic [7:0]  mem [0:65535];
  logic        tb_par = 1'b0;
  int          n_vec = 0;
  int          n_err = 0;

  oam_dma dut (
    .clock            (clock),
    .nreset           (nreset),
    .cpu_addr         (cpu_addr),
    .cpu_data_out     (cpu_data_out),
    .cpu_rw           (cpu_rw),
    .cpu_clock_enable (cpu_clock_enable),
    .bus_addr         (bus_addr),
    .bus_data_out     (bus_data_out),
    .bus_rw           (bus_rw),
    .bus_data_in      (bus_data_in),
    .dma_active       (dma_active)
  );

  always #5 clock = ~clock;

  assign bus_data_in = mem[bus_addr];

  // Expected parity of the current cycle: 0 on the first cycle after reset.
  always @(posedge clock) tb_par <= nreset ? 1'b0 : ~tb_par;

  // Page 2 holds i^5A; other pages are salted so the source page is observable.
  function automatic logic [7:0] exp_byte(input logic [7:0] pg, input logic [7:0] i);
    logic [7:0] salt;
    salt = (pg - 8'd2) << 4;
    return i ^ 8'h5A ^ salt;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // Starts a transfer on the current cycle; abort_at>0 resets after that many writes.
  task automatic run_dma(input logic [7:0] pg, input int want_par, input int abort_at);
    logic p;
    int   stall;
    int   guard;
    guard = 0;
    while (want_par >= 0 && tb_par != want_par[0] && guard < 4) begin
      cyc();
      guard++;
    end
    cpu_addr = 16'h4014; cpu_rw = 1'b0; cpu_data_out = pg;
    #1;
    p = tb_par;
    chk("trig_active", {31'd0, dma_active}, 32'd0);
    chk("trig_pass_rw", {31'd0, bus_rw}, 32'd0);
    chk("trig_pass_addr", {16'd0, bus_addr}, 32'h4014);
    cyc();
    cpu_addr = 16'h8123; cpu_rw = 1'b1; cpu_data_out = 8'hEE;
    #1;
    stall = 0;
    chk("halt_cen", {31'd0, cpu_clock_enable}, 32'd0);
    chk("halt_rw", {31'd0, bus_rw}, 32'd1);
    chk("halt_addr", {16'd0, bus_addr}, 32'h8123);
    chk("halt_active", {31'd0, dma_active}, 32'd1);
    if (!cpu_clock_enable) stall++;
    if (p) begin
      cyc();
      chk("align_cen", {31'd0, cpu_clock_enable}, 32'd0);
      chk("align_rw", {31'd0, bus_rw}, 32'd1);
      chk("align_addr", {16'd0, bus_addr}, 32'h8123);
      if (!cpu_clock_enable) stall++;
    end
    for (int i = 0; i < 256; i++) begin
      cyc();
      chk($sformatf("rd_addr[%0d]", i), {16'd0, bus_addr}, {16'd0, pg, i[7:0]});
      chk($sformatf("rd_rw[%0d]", i), {31'd0, bus_rw}, 32'd1);
      chk($sformatf("rd_par[%0d]", i), {31'd0, tb_par}, 32'd0);
      if (!cpu_clock_enable) stall++;
      cyc();
      chk($sformatf("wr_addr[%0d]", i), {16'd0, bus_addr}, 32'h2004);
      chk($sformatf("wr_rw[%0d]", i), {31'd0, bus_rw}, 32'd0);
      chk($sformatf("wr_data[%0d]", i), {24'd0, bus_data_out}, {24'd0, exp_byte(pg, i[7:0])});
      if (!cpu_clock_enable) stall++;
      if (abort_at > 0 && i + 1 == abort_at) begin
        nreset = 1'b1;
        cyc();
        nreset = 1'b0;
        chk("rst_cen", {31'd0, cpu_clock_enable}, 32'd1);
        chk("rst_active", {31'd0, dma_active}, 32'd0);
        chk("rst_addr", {16'd0, bus_addr}, 32'h8123);
        for (int k = 0; k < 20; k++) begin
          cyc();
          chk("post_rst_no_wr", {31'd0, bus_rw}, 32'd1);
          chk("post_rst_active", {31'd0, dma_active}, 32'd0);
        end
        return;
      end
    end
    cyc();
    chk("resume_cen", {31'd0, cpu_clock_enable}, 32'd1);
    chk("resume_active", {31'd0, dma_active}, 32'd0);
    chk("stall_cycles", stall, p ? 32'd514 : 32'd513);
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = exp_byte(a[15:8], a[7:0]);

    nreset = 1'b1;
    cyc(); cyc();
    chk("reset_cen", {31'd0, cpu_clock_enable}, 32'd1);
    chk("reset_active", {31'd0, dma_active}, 32'd0);
    nreset = 1'b0;

    // Passthrough
    cpu_addr = 16'h1234; cpu_rw = 1'b1; cpu_data_out = 8'h99;
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("pt_addr", {16'd0, bus_addr}, 32'h1234);
      chk("pt_rw", {31'd0, bus_rw}, 32'd1);
      chk("pt_data", {24'd0, bus_data_out}, 32'h99);
      chk("pt_cen", {31'd0, cpu_clock_enable}, 32'd1);
      chk("pt_active", {31'd0, dma_active}, 32'd0);
    end

    // Non-trigger accesses
    cpu_addr = 16'h4015; cpu_rw = 1'b0; cpu_data_out = 8'h02;
    cyc();
    cpu_addr = 16'h4014; cpu_rw = 1'b1;
    cyc();
    chk("nt_w4015_active", {31'd0, dma_active}, 32'd0);
    cpu_addr = 16'h1000;
    cyc();
    chk("nt_r4014_active", {31'd0, dma_active}, 32'd0);
    chk("nt_r4014_cen", {31'd0, cpu_clock_enable}, 32'd1);

    run_dma(8'h02, 0, 0);    // even-aligned
    cyc();
    run_dma(8'h02, 1, 0);    // odd-aligned
    cyc();
    run_dma(8'h02, 0, 100);  // reset after write #100
    cyc();
    run_dma(8'h07, -1, 0);   // back-to-back: second trigger on the resume cycle
    run_dma(8'h03, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
